// File: rtl/mod_recon_dp.sv
// mod_recon_dp -- sequential reconstruction datapath (inverse of the modulo unit).
// Rebuilds dividend = Q*B + R with one shift-and-add step per clock, WIDTH steps
// per operation. It uses the same start/done handshake as the modulo datapath, so
// a single controller can drive either unit.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     request, sampled only while idle
//   Q, B, R   quotient (multiplier), divisor (multiplicand), remainder (addend)
//   result    low WIDTH bits of Q*B+R (registered, held until next op completes)
//   result_hi high WIDTH bits of Q*B+R
//   overflow  result_hi != 0
//   busy      high while running or completing
//   done      one-cycle pulse, result valid
module mod_recon_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_overflow;

  // Accumulator value after the current step; also feeds the result registers
  // on the final step so they are valid in the same cycle done rises.
  logic [2*WIDTH-1:0] w_acc_nxt;
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc    <= {{WIDTH{1'b0}}, R};
            r_mcand  <= {{WIDTH{1'b0}}, B};
            r_mplier <= Q;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // Fixed latency: always WIDTH steps, even if the multiplier runs out early.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state     <= S_DONE;
            r_result    <= w_acc_nxt[WIDTH-1:0];
            r_result_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
            r_overflow  <= |w_acc_nxt[2*WIDTH-1:WIDTH];
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign overflow  = r_overflow;
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_mod_recon_dp.sv
module tb_mod_recon_dp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] Q = '0, B = '0, R = '0;
  logic [31:0] result, result_hi;
  logic        overflow, busy, done;

  logic        start8 = 1'b0;
  logic [7:0]  Q8 = '0, B8 = '0, R8 = '0;
  logic [7:0]  result8, result_hi8;
  logic        overflow8, busy8, done8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_recon_dp #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Q(Q), .B(B), .R(R),
    .result(result), .result_hi(result_hi), .overflow(overflow),
    .busy(busy), .done(done)
  );

  mod_recon_dp #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .Q(Q8), .B(B8), .R(R8),
    .result(result8), .result_hi(result_hi8), .overflow(overflow8),
    .busy(busy8), .done(done8)
  );

  // Reference: the full-width product plus addend in plain arithmetic.
  function automatic logic [63:0] model32(input logic [31:0] q, b, r);
    return 64'(q) * 64'(b) + 64'(r);
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] q, b, r);
    return 16'(q) * 16'(b) + 16'(r);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Launch one operation and wait for done. lat = edges from accept to done.
  task automatic do_op(input logic [31:0] q, b, r, output int lat);
    Q = q; B = b; R = r; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op8(input logic [7:0] q, b, r, output int lat);
    Q8 = q; B8 = b; R8 = r; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({result, result_hi, overflow, busy, done} !== 67'd0) begin
      failures++;
      $display("FAIL reset_outputs: got res=%h hi=%h ov=%b busy=%b done=%b, need all 0",
               result, result_hi, overflow, busy, done);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    do_op(32'd7, 32'd5, 32'd3, lat);
    checks++;
    if (lat !== 32) begin
      failures++; $display("FAIL basic_latency: got %0d need 32", lat);
    end
    checks++;
    if (result !== 32'd38 || result_hi !== 32'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got %h/%h/%b need 00000026/00000000/0", result, result_hi, overflow);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd38) begin
      failures++;
      $display("FAIL basic_after_done: done=%b busy=%b res=%h need 0 0 00000026", done, busy, result);
    end
  endtask

  task automatic test_edges();
    int lat;
    do_op(32'd0, 32'hDEADBEEF, 32'h1234, lat); tick();
    checks++;
    if (result !== 32'h1234 || result_hi !== 32'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL zero_mult: got %h/%h/%b need 00001234/00000000/0", result, result_hi, overflow);
    end
    do_op(32'd1, 32'd9, 32'd0, lat); tick();
    checks++;
    if (result !== 32'd9) begin
      failures++; $display("FAIL one_mult: got %h need 00000009", result);
    end
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    checks++;
    if (result !== 32'h0 || result_hi !== 32'hFFFFFFFF || overflow !== 1'b1) begin
      failures++;
      $display("FAIL max_ops: got %h/%h/%b need 00000000/ffffffff/1", result, result_hi, overflow);
    end
    tick();
  endtask

  // Outputs must hold the previous result during RUN; late operand changes are ignored.
  task automatic test_hold_and_late_operands();
    logic [31:0] q, b, r, prev;
    logic [63:0] exp;
    int lat;
    bit hold_ok, busy_ok;
    q = $urandom; b = $urandom; r = $urandom;
    exp = model32(q, b, r);
    prev = result;
    Q = q; B = b; R = r; start = 1'b1;
    tick();
    start = 1'b0;
    hold_ok = 1'b1; busy_ok = 1'b1;
    lat = 0;
    while (!done && lat < 100) begin
      if (result !== prev) hold_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      Q = $urandom; B = $urandom; R = $urandom; start = $urandom_range(0, 1);
      tick();
      lat++;
    end
    start = 1'b0;
    checks++;
    if (!hold_ok || !busy_ok) begin
      failures++;
      $display("FAIL hold_during_run: hold_ok=%b busy_ok=%b need 1 1", hold_ok, busy_ok);
    end
    checks++;
    if (lat !== 32 || {result_hi, result} !== exp || overflow !== (exp[63:32] != 0)) begin
      failures++;
      $display("FAIL late_operands: lat=%0d got %h%h ov=%b need lat 32 %h", lat, result_hi, result, overflow, exp);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] q, b, r;
    logic [63:0] exp;
    int lat;
    for (int i = 0; i < 10; i++) begin
      q = $urandom; b = $urandom; r = $urandom;
      if (i == 0) q = q & 32'hFF;
      if (i == 1) b = 32'h8000_0000;
      exp = model32(q, b, r);
      do_op(q, b, r, lat);
      checks++;
      if (lat !== 32 || {result_hi, result} !== exp || overflow !== (exp[63:32] != 0)) begin
        failures++;
        $display("FAIL random_%0d: q=%h b=%h r=%h lat=%0d got %h%h ov=%b need %h",
                 i, q, b, r, lat, result_hi, result, overflow, exp);
      end
      tick();
    end
  endtask

  // start held high: a new op is accepted two edges after each done edge.
  task automatic test_back_to_back();
    int t_done[$];
    logic [31:0] res_seen[$];
    Q = 32'd3; B = 32'd4; R = 32'd1; start = 1'b1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      tick();
      if (done) begin t_done.push_back(cyc); res_seen.push_back(result); end
      if (busy && !done) begin Q = $urandom; B = $urandom; R = $urandom; end
      else begin Q = 32'd3; B = 32'd4; R = 32'd1; end
    end
    start = 1'b0;
    Q = 32'd3; B = 32'd4; R = 32'd1;
    checks++;
    if (t_done.size() < 3) begin
      failures++; $display("FAIL b2b_count: got %0d done pulses need >=3", t_done.size());
    end else begin
      for (int i = 1; i < t_done.size(); i++) begin
        checks++;
        if (t_done[i] - t_done[i-1] !== 34) begin
          failures++; $display("FAIL b2b_period_%0d: got %0d need 34", i, t_done[i] - t_done[i-1]);
        end
      end
      foreach (res_seen[i]) begin
        checks++;
        if (res_seen[i] !== 32'd13) begin
          failures++; $display("FAIL b2b_result_%0d: got %h need 0000000d", i, res_seen[i]);
        end
      end
    end
    repeat (40) tick();
  endtask

  task automatic test_reset_abort();
    int lat;
    bit saw_done;
    checks++;
    if (result === 32'd0) begin
      failures++; $display("FAIL abort_precond: result is 0, need a nonzero prior result");
    end
    Q = 32'd11; B = 32'd13; R = 32'd17; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({result, result_hi, overflow, busy, done} !== 67'd0) begin
      failures++;
      $display("FAIL abort_outputs: got res=%h hi=%h ov=%b busy=%b done=%b need all 0",
               result, result_hi, overflow, busy, done);
    end
    repeat (2) tick();
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++; $display("FAIL abort_no_done: got activity after abort, need none");
    end
    do_op(32'd2, 32'd2, 32'd2, lat);
    checks++;
    if (lat !== 32 || result !== 32'd6) begin
      failures++; $display("FAIL after_abort: lat=%0d res=%h need 32 00000006", lat, result);
    end
    tick();
  endtask

  task automatic test_width8();
    logic [7:0] q, b, r;
    logic [15:0] exp;
    int lat;
    do_op8(8'hFF, 8'hFF, 8'hFF, lat);
    checks++;
    if (lat !== 8 || result8 !== 8'h00 || result_hi8 !== 8'hFF || overflow8 !== 1'b1) begin
      failures++;
      $display("FAIL w8_max: lat=%0d got %h/%h/%b need 8 00/ff/1", lat, result8, result_hi8, overflow8);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      q = 8'($urandom); b = 8'($urandom); r = 8'($urandom);
      exp = model8(q, b, r);
      do_op8(q, b, r, lat);
      checks++;
      if (lat !== 8 || {result_hi8, result8} !== exp || overflow8 !== (exp[15:8] != 0)) begin
        failures++;
        $display("FAIL w8_random_%0d: q=%h b=%h r=%h lat=%0d got %h%h need %h",
                 i, q, b, r, lat, result_hi8, result8, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_hold_and_late_operands();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
